carfield_region_filter: RTL
===========================

# carfield_region_filter

Runtime-programmable address region filter for the Carfield host interconnect. It generalises the static island address map (L2 ports, Spatz, PULP, mailbox, peripherals) into a table of `NumRegions` base/size/enable entries. Reset values come from parameters, and the table can be rewritten at runtime. Each incoming request address is decoded against the table through a one-stage valid/ready pipeline; misses are tagged and logged. It sits between the host crossbar address channel and the island demux.

## Interface
- `NumRegions`, 8: number of table entries (1..32).
- `AddrWidth`, 64: address width (matches `doub_bt`).
- `RstBase`, all 0: array [NumRegions] of reset base addresses.
- `RstSize`, all 0: array [NumRegions] of reset sizes in bytes.
- `RstEn`, all 0: bit vector [NumRegions] of reset enables.
- `CntWidth`, 16: width of the miss counter.
- `IdxW`, derived: `max(1, $clog2(NumRegions))`.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_addr_i`  in  AddrWidth  request address.
- `out_valid_o`  out  1  decoded result valid.
- `out_ready_i`  in  1  downstream ready.
- `out_addr_o`  out  AddrWidth  registered request address.
- `out_hit_o`  out  1  address matched an enabled region.
- `out_idx_o`  out  IdxW  matching region index; 0 on miss.
- `cfg_we_i`  in  1  table write strobe.
- `cfg_idx_i`  in  IdxW  entry to write.
- `cfg_base_i`  in  AddrWidth  new base.
- `cfg_size_i`  in  AddrWidth  new size.
- `cfg_en_i`  in  1  new enable.
- `cfg_err_o`  out  1  one-cycle pulse on a rejected cfg write.
- `lock_i`  in  1  lock request (see Configuration).
- `locked_o`  out  1  table locked.
- `err_clr_i`  in  1  clear the miss log.
- `err_cnt_o`  out  CntWidth  saturating miss count.
- `err_addr_o`  out  AddrWidth  address of first logged miss.

## Operation
- **Reset:** table is loaded from `RstBase`/`RstSize`/`RstEn`. `out_valid_o`=0, `out_addr_o`=0, `out_hit_o`=0, `out_idx_o`=0, `cfg_err_o`=0, `locked_o`=0, `err_cnt_o`=0, `err_addr_o`=0.
- **Match rule for entry i:**
  - Requires `en[i]` and `size[i]!=0` and `addr>=base[i]` and `(addr-base[i])<size[i]`.
  - The subtraction is done in AddrWidth bits, so regions ending at 2^AddrWidth match without overflow.
  - Size 0 never matches.
- **Priority:** overlapping regions are legal; the lowest index wins.
- **Pipeline:**
  - Single output register with `req_ready_o = !out_valid_o || out_ready_i` (combinational from `out_ready_i`).
  - A request is accepted when `req_valid_i && req_ready_o`. Decode results are captured into the output register.
  - The output register holds stable while `out_valid_o && !out_ready_i`.
- **Config write:**
  - Takes effect at the clock edge and is visible to decode from the next cycle.
  - A request accepted in the same cycle as a write decodes against the old table.
  - `cfg_idx_i >= NumRegions` is dropped and pulses `cfg_err_o`.
- **Miss log:** on each accepted request with no hit:
  - `err_cnt_o` increments, saturating at 2^CntWidth-1.
  - If `err_cnt_o` was 0, `err_addr_o` captures the address.
- **Miss log clear:** `err_clr_i` zeroes count and address. If a miss is accepted in the same cycle, clear applies first: count becomes 1 and the address is captured.
- **Reset mid-operation:** any held output is discarded. `out_valid_o` goes to 0 asynchronously and runtime table writes are lost.

## Timing
- Latency is 1 cycle from acceptance to `out_valid_o`; throughput is 1 request/cycle when `out_ready_i`=1.
- The decode path is combinational from `req_addr_i` and the table into the output register only. No output is combinational from `req_addr_i`.
- `cfg_err_o` asserts the cycle after the offending write, for 1 cycle.
- `err_cnt_o` and `err_addr_o` update the cycle after acceptance.
- `locked_o` rises the cycle after `lock_i`.

## Configuration
- Macro: `CARFIELD_REGION_FILTER_LOCK_EN`.
- **Defined:**
  - `lock_i`=1 sets a sticky lock, cleared only by `rst_ni`.
  - While locked, every `cfg_we_i` is dropped and pulses `cfg_err_o`.
  - A write in the same cycle as `lock_i` still commits.
  - `locked_o` reflects the lock.
- **Undefined:** `lock_i` is ignored, `locked_o` is tied 0, and writes are never rejected for lock reasons.

## Test plan
- **Reset map:** entry0 = 0x78000000/0x200000, entry1 = 0x78200000/0x200000, both enabled.
  - 0x781FFFFF -> hit, idx 0.
  - 0x78200000 -> hit, idx 1.
  - 0x78400000 -> miss; `err_cnt_o`=1, `err_addr_o`=0x78400000.
- **Overlap and top of space:**
  - entry3 = 0x51000000/0x800000 and entry5 = 0x50000000/0x2000000, both enabled. 0x51000010 -> idx 3.
  - entry7 base = 0xFFFF_FFFF_FFFF_F000, size 0x1000. 0xFFFF_FFFF_FFFF_FFFF -> hit, idx 7.
- **Backpressure:**
  - Hold `out_ready_i`=0 for 3 cycles with requests streaming. `req_ready_o` is 0 while full and the output is stable.
  - Release: back-to-back results in order, none lost or duplicated.
- **Config race:**
  - Write entry0 size=0 in the same cycle a request to 0x78000000 is accepted -> hit, idx 0.
  - Next request to 0x78000000 -> miss.
  - Write `cfg_idx_i`=NumRegions -> `cfg_err_o` pulse, table unchanged.
- **Miss log:**
  - 3 misses, then `err_clr_i` coincident with a miss at 0x0 -> count 1, addr 0x0.
  - With `CntWidth`=2: 5 misses -> count 3.
- **Lock (macro defined):**
  - `lock_i` plus a write to entry2 in the same cycle -> write commits, `locked_o`=1.
  - A later write -> `cfg_err_o` pulse, entry unchanged.
  - Repeat with the macro undefined -> the later write commits, `locked_o`=0.

Source files
------------

// File: rtl/carfield_region_filter.sv
// Runtime-programmable base/size/enable region table with a one-stage decode pipeline and miss log.
// Optional sticky table lock enabled by defining CARFIELD_REGION_FILTER_LOCK_EN.
module carfield_region_filter #(
   parameter int unsigned NumRegions = 8,
   parameter int unsigned AddrWidth  = 64,
   parameter logic [NumRegions-1:0][AddrWidth-1:0] RstBase = '0,
   parameter logic [NumRegions-1:0][AddrWidth-1:0] RstSize = '0,
   parameter logic [NumRegions-1:0]                RstEn   = '0,
   parameter int unsigned CntWidth   = 16,
   parameter int unsigned IdxW       = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [AddrWidth-1:0] out_addr_o,
   output logic                 out_hit_o,
   output logic [IdxW-1:0]      out_idx_o,
   input  logic                 cfg_we_i,
   input  logic [IdxW-1:0]      cfg_idx_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [AddrWidth-1:0] cfg_size_i,
   input  logic                 cfg_en_i,
   output logic                 cfg_err_o,
   input  logic                 lock_i,
   output logic                 locked_o,
   input  logic                 err_clr_i,
   output logic [CntWidth-1:0]  err_cnt_o,
   output logic [AddrWidth-1:0] err_addr_o
);

   logic [NumRegions-1:0][AddrWidth-1:0] base_q;
   logic [NumRegions-1:0][AddrWidth-1:0] size_q;
   logic [NumRegions-1:0]                en_q;

   logic                 locked;
   logic                 accept;
   logic                 cfg_idx_ok;
   logic                 cfg_reject;
   logic                 cfg_commit;
   logic                 dec_hit;
   logic [IdxW-1:0]      dec_idx;
   logic [CntWidth-1:0]  cnt_base;

   assign req_ready_o = !out_valid_o || out_ready_i;
   assign accept      = req_valid_i && req_ready_o;

   assign cfg_idx_ok  = 32'(cfg_idx_i) < NumRegions;
   assign cfg_reject  = cfg_we_i && (!cfg_idx_ok || locked);
   assign cfg_commit  = cfg_we_i && !cfg_reject;

`ifdef CARFIELD_REGION_FILTER_LOCK_EN
   logic locked_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         locked_q <= 1'b0;
      end else if (lock_i) begin
         locked_q <= 1'b1;
      end
   end

   assign locked = locked_q;
`else
   logic unused_lock;

   assign unused_lock = lock_i;
   assign locked      = 1'b0;
`endif

   assign locked_o = locked;

   // Walk from the top index down so the lowest matching index is the last to assign.
   // The offset compare is AddrWidth wide, so regions ending at the top of the space work.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
         if (en_q[i] && (size_q[i] != '0) && (req_addr_i >= base_q[i]) &&
             ((req_addr_i - base_q[i]) < size_q[i])) begin
            dec_hit = 1'b1;
            dec_idx = IdxW'(i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q <= RstBase;
         size_q <= RstSize;
         en_q   <= RstEn;
      end else if (cfg_commit) begin
         for (int unsigned i = 0; i < NumRegions; i++) begin
            if (cfg_idx_i == IdxW'(i)) begin
               base_q[i] <= cfg_base_i;
               size_q[i] <= cfg_size_i;
               en_q[i]   <= cfg_en_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         out_addr_o  <= '0;
         out_hit_o   <= 1'b0;
         out_idx_o   <= '0;
         cfg_err_o   <= 1'b0;
      end else begin
         cfg_err_o <= cfg_reject;
         if (req_ready_o) begin
            out_valid_o <= req_valid_i;
            if (accept) begin
               out_addr_o <= req_addr_i;
               out_hit_o  <= dec_hit;
               out_idx_o  <= dec_idx;
            end
         end
      end
   end

   // A clear in the same cycle as a miss behaves as if the log were empty before the miss.
   assign cnt_base = err_clr_i ? '0 : err_cnt_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_o  <= '0;
         err_addr_o <= '0;
      end else if (accept && !dec_hit) begin
         err_cnt_o <= (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
         if (cnt_base == '0) begin
            err_addr_o <= req_addr_i;
         end
      end else if (err_clr_i) begin
         err_cnt_o  <= '0;
         err_addr_o <= '0;
      end
   end

endmodule
